// File: rtl/adc_idelay_tap_calib_if.sv
// Bundle between the tap calibrator and the capture / register side.
//  calib_start        start pulse from the register interface
//  adc_data_in        captured ADC data, one sample per cycle
//  idelay_ld          per-lane IODELAY LD strobe
//  idelay_cntvaluein  per-lane tap values, lane j in [j*TAP_BITS +: TAP_BITS]
//  calib_busy         calibration in progress
//  calib_done         calibration finished
//  calib_err          per-lane "no usable window" flags
// master: the calibrator.  slave: the surrounding logic / testbench.
interface adc_idelay_tap_calib_if #(
  parameter int unsigned ADC_DATA_WIDTH = 8,
  parameter int unsigned TAP_BITS       = 5
);
  logic                               calib_start;
  logic [ADC_DATA_WIDTH-1:0]          adc_data_in;
  logic [ADC_DATA_WIDTH-1:0]          idelay_ld;
  logic [TAP_BITS*ADC_DATA_WIDTH-1:0] idelay_cntvaluein;
  logic                               calib_busy;
  logic                               calib_done;
  logic [ADC_DATA_WIDTH-1:0]          calib_err;

  modport master (
    input  calib_start, adc_data_in,
    output idelay_ld, idelay_cntvaluein, calib_busy, calib_done, calib_err
  );

  modport slave (
    output calib_start, adc_data_in,
    input  idelay_ld, idelay_cntvaluein, calib_busy, calib_done, calib_err
  );
endinterface

// File: rtl/adc_idelay_tap_calib.sv
// Per-lane IODELAY training controller. For each lane in turn it sweeps all
// taps, checks the toggling ADC training pattern at each tap, tracks the
// longest passing run and finally loads the centre of that run.
//  adc_clk_bufr  capture-domain clock (also IODELAY C)
//  rst_sync      synchronous reset, active-high
//  bus           adc_idelay_tap_calib_if.master (start, data, LD/tap, status)
module adc_idelay_tap_calib #(
  parameter int unsigned ADC_DATA_WIDTH = 8,
  parameter int unsigned TAP_BITS       = 5,
  parameter int unsigned NUM_TAPS       = 32,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned COMPARE_CYCLES = 64,
  parameter int unsigned MIN_WINDOW     = 4
) (
  input logic                    adc_clk_bufr,
  input logic                    rst_sync,
  adc_idelay_tap_calib_if.master bus
);

  localparam int unsigned LANE_W  = (ADC_DATA_WIDTH > 1) ? $clog2(ADC_DATA_WIDTH) : 1;
  localparam int unsigned LEN_W   = TAP_BITS + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > COMPARE_CYCLES) ? SETTLE_CYCLES : COMPARE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT_TAP, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic [TAP_BITS-1:0] tap;
  logic [CNT_W-1:0]    cnt;
  logic                tap_fail;
  logic                prev_bit;
  logic [TAP_BITS-1:0] cur_start;
  logic [LEN_W-1:0]    cur_len;
  logic [TAP_BITS-1:0] best_start;
  logic [LEN_W-1:0]    best_len;
  logic [TAP_BITS-1:0] centre;

  logic                sample_bit_c;
  logic                last_tap_c;
  logic                close_c;
  logic                take_c;
  logic [LEN_W-1:0]    new_len_c;
  logic [TAP_BITS-1:0] new_start_c;
  logic [TAP_BITS-1:0] centre_c;
  logic                window_ok_c;

  // Run-tracker update for the tap just checked; a run closes on a failing
  // tap or at the last tap, and only a strictly longer run replaces the best.
  always_comb begin
    sample_bit_c = bus.adc_data_in[lane];
    last_tap_c   = (tap == TAP_BITS'(NUM_TAPS - 1));
    new_len_c    = tap_fail ? cur_len : cur_len + LEN_W'(1);
    new_start_c  = (!tap_fail && (cur_len == '0)) ? tap : cur_start;
    close_c      = tap_fail || last_tap_c;
    take_c       = close_c && (new_len_c > best_len);
    window_ok_c  = (best_len >= LEN_W'(MIN_WINDOW));
    centre_c     = best_start + TAP_BITS'((best_len - LEN_W'(1)) >> 1);
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge adc_clk_bufr) begin
    if (rst_sync) begin
      state                 <= S_IDLE;
      lane                  <= '0;
      tap                   <= '0;
      cnt                   <= '0;
      tap_fail              <= 1'b0;
      prev_bit              <= 1'b0;
      cur_start             <= '0;
      cur_len               <= '0;
      best_start            <= '0;
      best_len              <= '0;
      centre                <= '0;
      bus.idelay_ld         <= '0;
      bus.idelay_cntvaluein <= '0;
      bus.calib_busy        <= 1'b0;
      bus.calib_done        <= 1'b0;
      bus.calib_err         <= '0;
    end else begin
      bus.idelay_ld <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.calib_start) begin
            state          <= S_LOAD;
            bus.calib_busy <= 1'b1;
            bus.calib_done <= 1'b0;
            bus.calib_err  <= '0;
            lane           <= '0;
            tap            <= '0;
            cur_start      <= '0;
            cur_len        <= '0;
            best_start     <= '0;
            best_len       <= '0;
          end
        end

        S_LOAD: begin
          bus.idelay_ld <= ADC_DATA_WIDTH'(1) << lane;
          bus.idelay_cntvaluein[lane*TAP_BITS +: TAP_BITS] <= tap;
          tap_fail <= 1'b0;
          cnt      <= '0;
          state    <= S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // First sample is the reference; each later one must invert the previous.
        S_CHECK: begin
          prev_bit <= sample_bit_c;
          if ((cnt != '0) && (sample_bit_c == prev_bit)) tap_fail <= 1'b1;
          if (cnt == CNT_W'(COMPARE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_NEXT_TAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_NEXT_TAP: begin
          cur_start <= new_start_c;
          cur_len   <= tap_fail ? '0 : new_len_c;
          if (take_c) begin
            best_start <= new_start_c;
            best_len   <= new_len_c;
          end
          if (last_tap_c) begin
            state <= S_EVAL;
          end else begin
            tap   <= tap + TAP_BITS'(1);
            state <= S_LOAD;
          end
        end

        S_EVAL: begin
          if (window_ok_c) begin
            centre <= centre_c;
          end else begin
            centre              <= '0;
            bus.calib_err[lane] <= 1'b1;
          end
          state <= S_APPLY;
        end

        S_APPLY: begin
          bus.idelay_ld <= ADC_DATA_WIDTH'(1) << lane;
          bus.idelay_cntvaluein[lane*TAP_BITS +: TAP_BITS] <= centre;
          if (lane == LANE_W'(ADC_DATA_WIDTH - 1)) begin
            bus.calib_busy <= 1'b0;
            bus.calib_done <= 1'b1;
            state          <= S_DONE;
          end else begin
            lane       <= lane + LANE_W'(1);
            tap        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            state      <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_idelay_tap_calib.sv
// Directed testbench for adc_idelay_tap_calib. An IODELAY/ADC model latches
// each LD tap per lane and produces a toggling pattern only at taps marked
// as passing in that lane's mask; otherwise the lane sits at 0.
module tb_adc_idelay_tap_calib;

  localparam int unsigned W        = 8;
  localparam int unsigned TB       = 5;
  localparam int unsigned SETTLE   = 4;
  localparam int unsigned COMPARE  = 8;
  localparam int unsigned LANE_CYC = 32 * (1 + SETTLE + COMPARE + 1) + 2;
  localparam int unsigned RUN_CYC  = W * LANE_CYC;
  localparam int unsigned LIMIT    = RUN_CYC + 1000;

  logic clk;
  logic rst_sync;

  adc_idelay_tap_calib_if #(.ADC_DATA_WIDTH(W), .TAP_BITS(TB)) bus ();

  adc_idelay_tap_calib #(
    .ADC_DATA_WIDTH(W), .TAP_BITS(TB), .NUM_TAPS(32),
    .SETTLE_CYCLES(SETTLE), .COMPARE_CYCLES(COMPARE), .MIN_WINDOW(4)
  ) dut (
    .adc_clk_bufr(clk),
    .rst_sync    (rst_sync),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]   pass_mask [W];
  logic [TB-1:0] tap_reg   [W];
  logic [TB-1:0] last_ld   [W];
  int            ld_count = 0;

  // IODELAY model: latch the tap on each LD strobe.
  always @(posedge clk) begin
    for (int j = 0; j < W; j++) begin
      if (bus.idelay_ld[j]) begin
        tap_reg[j] <= bus.idelay_cntvaluein[j*TB +: TB];
        last_ld[j] <= bus.idelay_cntvaluein[j*TB +: TB];
      end
    end
    ld_count <= ld_count + $countones(bus.idelay_ld);
  end

  // ADC model: toggling pattern at passing taps, stuck at 0 elsewhere.
  initial begin
    logic tog;
    tog = 1'b0;
    for (int j = 0; j < W; j++) begin
      tap_reg[j]   = '0;
      pass_mask[j] = '0;
    end
    bus.adc_data_in = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      for (int j = 0; j < W; j++)
        bus.adc_data_in[j] = pass_mask[j][tap_reg[j]] ? tog : 1'b0;
    end
  end

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_all_masks(input logic [31:0] m);
    for (int j = 0; j < W; j++) pass_mask[j] = m;
  endtask

  // One full calibration run with end-of-run checks; optionally pulses start mid-run.
  task automatic run_cal(input string name, input logic [TB*W-1:0] exp_taps,
                         input logic [W-1:0] exp_err, input bit busy_pulse);
    int n;
    int ld0;
    @(negedge clk);
    bus.calib_start = 1'b1;
    @(posedge clk);
    #1;
    bus.calib_start = 1'b0;
    ld0 = ld_count;
    checks++;
    if (bus.calib_busy !== 1'b1 || bus.calib_done !== 1'b0) begin
      errors++;
      $display("FAIL %s first_cycle: busy=%b done=%b required busy=1 done=0",
               name, bus.calib_busy, bus.calib_done);
    end
    n = 0;
    while (bus.calib_done !== 1'b1 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      bus.calib_start = (busy_pulse && n == 1000) ? 1'b1 : 1'b0;
    end
    bus.calib_start = 1'b0;
    checks++;
    if (n != RUN_CYC) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles required %0d", name, n, RUN_CYC);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.calib_busy !== 1'b0 || bus.calib_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_state: busy=%b done=%b required busy=0 done=1",
               name, bus.calib_busy, bus.calib_done);
    end
    checks++;
    if (bus.calib_err !== exp_err) begin
      errors++;
      $display("FAIL %s calib_err: got %h required %h", name, bus.calib_err, exp_err);
    end
    checks++;
    if (bus.idelay_cntvaluein !== exp_taps) begin
      errors++;
      $display("FAIL %s cntvaluein: got %h required %h", name, bus.idelay_cntvaluein, exp_taps);
    end
    checks++;
    if (ld_count - ld0 != W * 33) begin
      errors++;
      $display("FAIL %s ld_pulses: got %0d required %0d", name, ld_count - ld0, W * 33);
    end
    for (int j = 0; j < W; j++) begin
      checks++;
      if (last_ld[j] !== exp_taps[j*TB +: TB]) begin
        errors++;
        $display("FAIL %s final_ld lane%0d: got %0d required %0d",
                 name, j, last_ld[j], exp_taps[j*TB +: TB]);
      end
    end
  endtask

  task automatic test_reset;
    bit bad;
    int ld0;
    rst_sync = 1'b1;
    bus.calib_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_sync = 1'b0;
    ld0 = ld_count;
    bad = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.idelay_ld !== '0 || bus.idelay_cntvaluein !== '0 || bus.calib_busy !== 1'b0 ||
          bus.calib_done !== 1'b0 || bus.calib_err !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: outputs nonzero during idle, required all 0");
    end
    checks++;
    if (ld_count != ld0) begin
      errors++;
      $display("FAIL reset_ld: got %0d LD pulses required 0", ld_count - ld0);
    end
  endtask

  task automatic test_center_window;
    set_all_masks(range_mask(10, 19));
    run_cal("center_window", {W{5'd14}}, 8'h00, 1'b0);
  endtask

  task automatic test_two_windows;
    logic [TB*W-1:0] e;
    set_all_masks(range_mask(10, 19));
    pass_mask[3] = range_mask(2, 5) | range_mask(20, 27);
    e = {W{5'd14}};
    e[3*TB +: TB] = 5'd23;
    run_cal("two_windows", e, 8'h00, 1'b0);
  endtask

  task automatic test_narrow_lane;
    logic [TB*W-1:0] e;
    set_all_masks(range_mask(10, 19));
    pass_mask[5] = range_mask(0, 2);
    e = {W{5'd14}};
    e[5*TB +: TB] = 5'd0;
    run_cal("narrow_lane", e, 8'h20, 1'b0);
  endtask

  task automatic test_all_pass;
    set_all_masks(32'hFFFF_FFFF);
    run_cal("all_pass", {W{5'd15}}, 8'h00, 1'b0);
  endtask

  task automatic test_equal_runs;
    set_all_masks(range_mask(0, 4) | range_mask(10, 14));
    run_cal("equal_runs", {W{5'd2}}, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_sweep;
    set_all_masks(range_mask(10, 19));
    @(negedge clk);
    bus.calib_start = 1'b1;
    @(negedge clk);
    bus.calib_start = 1'b0;
    repeat (600) @(negedge clk);
    checks++;
    if (bus.calib_busy !== 1'b1 || bus.idelay_cntvaluein === '0) begin
      errors++;
      $display("FAIL mid_sweep_pre: busy=%b cnt=%h required busy=1 cnt nonzero",
               bus.calib_busy, bus.idelay_cntvaluein);
    end
    rst_sync = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.calib_busy !== 1'b0 || bus.calib_done !== 1'b0 || bus.calib_err !== '0 ||
        bus.idelay_ld !== '0 || bus.idelay_cntvaluein !== '0) begin
      errors++;
      $display("FAIL mid_sweep_reset: busy=%b done=%b err=%h ld=%h cnt=%h required all 0",
               bus.calib_busy, bus.calib_done, bus.calib_err, bus.idelay_ld, bus.idelay_cntvaluein);
    end
    bus.calib_start = 1'b1;
    @(posedge clk);
    #1;
    rst_sync = 1'b0;
    bus.calib_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.calib_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_during_reset: busy=%b required 0", bus.calib_busy);
    end
  endtask

  task automatic test_start_while_busy;
    set_all_masks(range_mask(10, 19));
    run_cal("start_while_busy", {W{5'd14}}, 8'h00, 1'b1);
  endtask

  task automatic test_rerun_after_done;
    logic [TB*W-1:0] e;
    checks++;
    if (bus.calib_done !== 1'b1) begin
      errors++;
      $display("FAIL rerun_pre: done=%b required 1", bus.calib_done);
    end
    set_all_masks(range_mask(0, 4) | range_mask(10, 14));
    pass_mask[7] = range_mask(1, 3);
    e = {W{5'd2}};
    e[7*TB +: TB] = 5'd0;
    run_cal("rerun_after_done", e, 8'h80, 1'b0);
  endtask

  initial begin
    rst_sync = 1'b1;
    bus.calib_start = 1'b0;
    test_reset();
    test_center_window();
    test_two_windows();
    test_narrow_lane();
    test_all_pass();
    test_equal_runs();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_rerun_after_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
